// File: rtl/feed_countdown_timer_pkg.sv
// Shared definitions for the feeder countdown slice.
//   state_t      : FSM state encoding (IDLE / RUN / FEED / EMPTY)
//   MAX_MIN_SEC  : largest minutes/seconds value shown on the LCD
//   MAX_HOURS    : largest hours value (two LCD digits)
//   clamp()      : saturates an operator-entered field to its display limit
package feed_countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FEED  = 2'd2,
        ST_EMPTY = 2'd3
    } state_t;

    localparam logic [7:0] MAX_MIN_SEC = 8'd59;
    localparam logic [7:0] MAX_HOURS   = 8'd99;

    function automatic logic [7:0] clamp(input logic [7:0] value, input logic [7:0] limit);
        return (value > limit) ? limit : value;
    endfunction

endpackage

// File: rtl/feed_countdown_timer_hms_down_counter.sv
// HH:MM:SS down counter with borrow chain.
//   clk, reset  : clock, asynchronous active-low reset (clears to 00:00:00)
//   load_i      : load h_i/m_i/s_i (takes priority over dec_i)
//   dec_i       : decrement one second; ignored when already 00:00:00
//   h_o/m_o/s_o : current value
//   zero_o      : value is 00:00:00
//   last_o      : value is 00:00:01, i.e. the next decrement reaches zero
module hms_down_counter
    import feed_countdown_timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [7:0] h_i,
    input  logic [7:0] m_i,
    input  logic [7:0] s_i,
    input  logic       dec_i,
    output logic [7:0] h_o,
    output logic [7:0] m_o,
    output logic [7:0] s_o,
    output logic       zero_o,
    output logic       last_o
);

    logic [7:0] r_h;
    logic [7:0] r_m;
    logic [7:0] r_s;
    logic       w_zero;

    assign w_zero = (r_h == 8'd0) && (r_m == 8'd0) && (r_s == 8'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_h <= 8'd0;
            r_m <= 8'd0;
            r_s <= 8'd0;
        end else if (load_i) begin
            r_h <= h_i;
            r_m <= m_i;
            r_s <= s_i;
        end else if (dec_i && !w_zero) begin
            // Seconds borrow from minutes, minutes borrow from hours.
            if (r_s != 8'd0) begin
                r_s <= r_s - 8'd1;
            end else begin
                r_s <= MAX_MIN_SEC;
                if (r_m != 8'd0) begin
                    r_m <= r_m - 8'd1;
                end else begin
                    r_m <= MAX_MIN_SEC;
                    r_h <= r_h - 8'd1;
                end
            end
        end
    end

    assign h_o    = r_h;
    assign m_o    = r_m;
    assign s_o    = r_s;
    assign zero_o = w_zero;
    assign last_o = (r_h == 8'd0) && (r_m == 8'd0) && (r_s == 8'd1);

endmodule

// File: rtl/feed_countdown_timer.sv
// Feeding-interval countdown ahead of the LCD1602 controller.
// Holds the interval and remaining portions, counts down in TICK_DIV-cycle
// ticks, requests a dispense when the countdown expires and waits for the
// motor stage's done pulse (with a tick-based timeout that raises fault_o).
//   clk, reset          : clock, asynchronous active-low reset
//   load_i              : latch interval_*_i / portions_i (IDLE, or EMPTY with portions_i != 0)
//   interval_h/m/s_i    : interval, clamped to 99:59:59
//   portions_i          : portions loaded into the hopper
//   start_i / stop_i    : begin-resume / pause the countdown
//   feed_done_i         : 1-cycle pulse, dispense finished
//   time_hours/minutes/seconds, porciones : LCD display values
//   feed_req_o          : dispense request, high throughout FEED
//   ready_o             : LCD enable, high from the first clock after reset
//   empty_o             : hopper empty
//   fault_o             : sticky dispense timeout flag
module feed_countdown_timer
    import feed_countdown_timer_pkg::*;
#(
    parameter int         CLOCK_FREQ   = 50_000_000,
    parameter int         TICK_DIV     = CLOCK_FREQ,
    parameter logic [7:0] FEED_TIMEOUT = 8'd10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [7:0] interval_h_i,
    input  logic [7:0] interval_m_i,
    input  logic [7:0] interval_s_i,
    input  logic [7:0] portions_i,
    input  logic       start_i,
    input  logic       stop_i,
    input  logic       feed_done_i,
    output logic [7:0] time_hours,
    output logic [7:0] time_minutes,
    output logic [7:0] time_seconds,
    output logic [7:0] porciones,
    output logic       feed_req_o,
    output logic       ready_o,
    output logic       empty_o,
    output logic       fault_o
);

    localparam int             TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0]  TICK_LAST = TW'(TICK_DIV - 1);

    state_t        r_state;
    state_t        w_next;
    logic [TW-1:0] r_tick_cnt;
    logic [7:0]    r_feed_ticks;
    logic [7:0]    r_int_h;
    logic [7:0]    r_int_m;
    logic [7:0]    r_int_s;
    logic [7:0]    r_porciones;
    logic          r_ready;
    logic          r_fault;

    logic          w_tick;
    logic          w_zero;
    logic          w_last;
    logic          w_load_user;
    logic          w_load_int;
    logic          w_dec;
    logic          w_run_entry;
    logic          w_feed_entry;
    logic          w_set_fault;
    logic          w_portion_dec;
    logic [7:0]    w_ld_h;
    logic [7:0]    w_ld_m;
    logic [7:0]    w_ld_s;

    // The divider also runs in FEED so the dispense timeout is measured in ticks.
    assign w_tick = ((r_state == ST_RUN) || (r_state == ST_FEED)) && (r_tick_cnt == TICK_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        w_load_user   = 1'b0;
        w_load_int    = 1'b0;
        w_dec         = 1'b0;
        w_run_entry   = 1'b0;
        w_feed_entry  = 1'b0;
        w_set_fault   = 1'b0;
        w_portion_dec = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_load_user = load_i;
                if (start_i && !stop_i) begin
                    if (r_porciones == 8'd0) begin
                        w_next = ST_EMPTY;
                    end else if (!w_zero) begin
                        w_next      = ST_RUN;
                        w_run_entry = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (stop_i) begin
                    w_next = ST_IDLE;
                end else if (w_tick) begin
                    w_dec = 1'b1;
                    if (w_last) begin
                        w_next       = ST_FEED;
                        w_feed_entry = 1'b1;
                    end
                end
            end
            ST_FEED: begin
                // A done pulse in the same cycle as the timeout still counts as success.
                if (feed_done_i && (r_porciones != 8'd0)) begin
                    w_portion_dec = 1'b1;
                    if (r_porciones == 8'd1) begin
                        w_next = ST_EMPTY;
                    end else begin
                        w_next      = ST_RUN;
                        w_load_int  = 1'b1;
                        w_run_entry = 1'b1;
                    end
                end else if (w_tick && (r_feed_ticks == FEED_TIMEOUT - 8'd1)) begin
                    w_set_fault = 1'b1;
                    w_next      = ST_IDLE;
                end
            end
            ST_EMPTY: begin
                if (load_i && (portions_i != 8'd0)) begin
                    w_load_user = 1'b1;
                    w_next      = ST_IDLE;
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tick_cnt <= '0;
        end else if (w_run_entry) begin
            r_tick_cnt <= '0;
        end else if ((r_state == ST_RUN) || (r_state == ST_FEED)) begin
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + 1'b1;
        end else begin
            r_tick_cnt <= '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_feed_ticks <= 8'd0;
        end else if (w_feed_entry) begin
            r_feed_ticks <= 8'd0;
        end else if ((r_state == ST_FEED) && w_tick) begin
            r_feed_ticks <= r_feed_ticks + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_int_h     <= 8'd0;
            r_int_m     <= 8'd0;
            r_int_s     <= 8'd0;
            r_porciones <= 8'd0;
            r_fault     <= 1'b0;
            r_ready     <= 1'b0;
        end else begin
            r_ready <= 1'b1;
            if (w_load_user) begin
                r_int_h     <= w_ld_h;
                r_int_m     <= w_ld_m;
                r_int_s     <= w_ld_s;
                r_porciones <= portions_i;
                r_fault     <= 1'b0;
            end else begin
                if (w_portion_dec) begin
                    r_porciones <= r_porciones - 8'd1;
                end
                if (w_set_fault) begin
                    r_fault <= 1'b1;
                end
            end
        end
    end

    // Operator loads are clamped; a post-dispense reload reuses the stored interval.
    assign w_ld_h = w_load_user ? clamp(interval_h_i, MAX_HOURS)   : r_int_h;
    assign w_ld_m = w_load_user ? clamp(interval_m_i, MAX_MIN_SEC) : r_int_m;
    assign w_ld_s = w_load_user ? clamp(interval_s_i, MAX_MIN_SEC) : r_int_s;

    hms_down_counter u_hms (
        .clk    (clk),
        .reset  (reset),
        .load_i (w_load_user | w_load_int),
        .h_i    (w_ld_h),
        .m_i    (w_ld_m),
        .s_i    (w_ld_s),
        .dec_i  (w_dec),
        .h_o    (time_hours),
        .m_o    (time_minutes),
        .s_o    (time_seconds),
        .zero_o (w_zero),
        .last_o (w_last)
    );

    assign porciones  = r_porciones;
    assign feed_req_o = (r_state == ST_FEED);
    assign empty_o    = (r_state == ST_EMPTY);
    assign fault_o    = r_fault;
    assign ready_o    = r_ready;

endmodule

// File: tb/tb_feed_countdown_timer.sv
// Self-checking bench for feed_countdown_timer (TICK_DIV=4, FEED_TIMEOUT=3).
// Each scenario task pushes the expected output snapshot to a scoreboard
// queue as it drives stimulus, then pops and compares it once the DUT has
// had the cycles needed to respond.
module tb_feed_countdown_timer;

    typedef struct packed {
        logic [7:0] h;
        logic [7:0] m;
        logic [7:0] s;
        logic [7:0] p;
        logic       req;
        logic       empty;
        logic       fault;
        logic       ready;
    } outs_t;

    typedef struct {
        string name;
        outs_t v;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       load_i = 1'b0;
    logic [7:0] interval_h_i = 8'd0;
    logic [7:0] interval_m_i = 8'd0;
    logic [7:0] interval_s_i = 8'd0;
    logic [7:0] portions_i = 8'd0;
    logic       start_i = 1'b0;
    logic       stop_i = 1'b0;
    logic       feed_done_i = 1'b0;
    logic [7:0] time_hours;
    logic [7:0] time_minutes;
    logic [7:0] time_seconds;
    logic [7:0] porciones;
    logic       feed_req_o;
    logic       ready_o;
    logic       empty_o;
    logic       fault_o;

    exp_t sb[$];
    int   totalChecks = 0;
    int   passedChecks = 0;

    always #5 clk = ~clk;

    feed_countdown_timer #(
        .CLOCK_FREQ   (4),
        .TICK_DIV     (4),
        .FEED_TIMEOUT (8'd3)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .load_i       (load_i),
        .interval_h_i (interval_h_i),
        .interval_m_i (interval_m_i),
        .interval_s_i (interval_s_i),
        .portions_i   (portions_i),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .feed_done_i  (feed_done_i),
        .time_hours   (time_hours),
        .time_minutes (time_minutes),
        .time_seconds (time_seconds),
        .porciones    (porciones),
        .feed_req_o   (feed_req_o),
        .ready_o      (ready_o),
        .empty_o      (empty_o),
        .fault_o      (fault_o)
    );

    // Expected snapshot with ready_o high (normal operation).
    function automatic outs_t mk(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                                 input logic [7:0] p, input logic req, input logic empty,
                                 input logic fault);
        return '{h: h, m: m, s: s, p: p, req: req, empty: empty, fault: fault, ready: 1'b1};
    endfunction

    function automatic outs_t snap();
        return '{h: time_hours, m: time_minutes, s: time_seconds, p: porciones,
                 req: feed_req_o, empty: empty_o, fault: fault_o, ready: ready_o};
    endfunction

    task automatic push(input string name, input outs_t v);
        exp_t e;
        e.name = name;
        e.v    = v;
        sb.push_back(e);
    endtask

    // Advance n clocks; return 1 time unit after the last rising edge.
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic doLoad(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                          input logic [7:0] p);
        interval_h_i = h;
        interval_m_i = m;
        interval_s_i = s;
        portions_i   = p;
        load_i       = 1'b1;
        cyc(1);
        load_i       = 1'b0;
    endtask

    task automatic doStart();
        start_i = 1'b1;
        cyc(1);
        start_i = 1'b0;
    endtask

    task automatic test_reset();
        exp_t  e;
        outs_t o;
        outs_t zeroOuts;
        zeroOuts = '0;
        reset = 1'b0;
        push("reset_hold", zeroOuts);
        cyc(5);
        e = sb.pop_front(); o = snap(); totalChecks++;
        if (o !== e.v) $display("[TB] FAIL %s: actual %h required %h", e.name, o, e.v);
        else passedChecks++;
        reset = 1'b1;
        push("reset_release_ready", mk(0, 0, 0, 0, 0, 0, 0));
        cyc(1);
        e = sb.pop_front(); o = snap(); totalChecks++;
        if (o !== e.v) $display("[TB] FAIL %s: actual %h required %h", e.name, o, e.v);
        else passedChecks++;
    endtask

    task automatic test_countdown();
        exp_t  e;
        outs_t o;
        push("load_00_01_02", mk(0, 1, 2, 3, 0, 0, 0));
        doLoad(8'd0, 8'd1, 8'd2, 8'd3);
        e = sb.pop_front(); o = snap(); totalChecks++;
        if (o !== e.v) $display("[TB] FAIL %s: actual %h required %h", e.name, o, e.v);
        else passedChecks++;
        doStart();
        push("no_tick_before_4clk", mk(0, 1, 2, 3, 0, 0, 0));
        push("first_tick_4clk", mk(0, 1, 1, 3, 0, 0, 0));
        push("borrow_at_12clk", mk(0, 0, 59, 3, 0, 0, 0));
        cyc(3);
        e = sb.pop_front(); o = snap(); totalChecks++;
        if (o !== e.v) $display("[TB] FAIL %s: actual %h required %h", e.name, o, e.v);
        else passedChecks++;
        cyc(1);
        e = sb.pop_front(); o = snap(); totalChecks++;
        if (o !== e.v) $display("[TB] FAIL %s: actual %h required %h", e.name, o, e.v);
        else passedChecks++;
        cyc(8);
        e = sb.pop_front(); o = snap(); totalChecks++;
        if (o !== e.v) $display("[TB] FAIL %s: actual %h required %h", e.name, o, e.v);
        else passedChecks++;
    endtask

    task automatic test_expiry();
        exp_t  e;
        outs_t o;
        int    waitCnt;
        // 59 remaining seconds at 4 clk per tick.
        push("feed_entry", mk(0, 0, 0, 3, 1, 0, 0));
        waitCnt = 0;
        while (feed_req_o !== 1'b1 && waitCnt < 300) begin
            cyc(1);
            waitCnt++;
        end
        totalChecks++;
        if (waitCnt != 236) $display("[TB] FAIL expiry_latency: actual %0d required 236 clk", waitCnt);
        else passedChecks++;
        e = sb.pop_front(); o = snap(); totalChecks++;
        if (o !== e.v) $display("[TB] FAIL %s: actual %h required %h", e.name, o, e.v);
        else passedChecks++;
        cyc(1);
        feed_done_i = 1'b1;
        push("done_reload", mk(0, 1, 2, 2, 0, 0, 0));
        cyc(1);
        feed_done_i = 1'b0;
        e = sb.pop_front(); o = snap(); totalChecks++;
        if (o !== e.v) $display("[TB] FAIL %s: actual %h required %h", e.name, o, e.v);
        else passedChecks++;
        push("run_after_reload", mk(0, 1, 1, 2, 0, 0, 0));
        cyc(4);
        e = sb.pop_front(); o = snap(); totalChecks++;
        if (o !== e.v) $display("[TB] FAIL %s: actual %h required %h", e.name, o, e.v);
        else passedChecks++;
        stop_i = 1'b1;
        cyc(1);
        stop_i = 1'b0;
    endtask

    task automatic test_empty();
        exp_t  e;
        outs_t o;
        push("clamp_load", mk(99, 59, 59, 4, 0, 0, 0));
        doLoad(8'd120, 8'd75, 8'd60, 8'd4);
        e = sb.pop_front(); o = snap(); totalChecks++;
        if (o !== e.v) $display("[TB] FAIL %s: actual %h required %h", e.name, o, e.v);
        else passedChecks++;
        doLoad(8'd0, 8'd0, 8'd2, 8'd1);
        doStart();
        push("last_portion_feed", mk(0, 0, 0, 1, 1, 0, 0));
        cyc(8);
        e = sb.pop_front(); o = snap(); totalChecks++;
        if (o !== e.v) $display("[TB] FAIL %s: actual %h required %h", e.name, o, e.v);
        else passedChecks++;
        feed_done_i = 1'b1;
        push("empty_after_done", mk(0, 0, 0, 0, 0, 1, 0));
        cyc(1);
        feed_done_i = 1'b0;
        e = sb.pop_front(); o = snap(); totalChecks++;
        if (o !== e.v) $display("[TB] FAIL %s: actual %h required %h", e.name, o, e.v);
        else passedChecks++;
        doStart();
        push("empty_ignores_start_and_zero_load", mk(0, 0, 0, 0, 0, 1, 0));
        doLoad(8'd0, 8'd0, 8'd3, 8'd0);
        cyc(4);
        e = sb.pop_front(); o = snap(); totalChecks++;
        if (o !== e.v) $display("[TB] FAIL %s: actual %h required %h", e.name, o, e.v);
        else passedChecks++;
        push("empty_reload_5", mk(0, 0, 5, 5, 0, 0, 0));
        doLoad(8'd0, 8'd0, 8'd5, 8'd5);
        e = sb.pop_front(); o = snap(); totalChecks++;
        if (o !== e.v) $display("[TB] FAIL %s: actual %h required %h", e.name, o, e.v);
        else passedChecks++;
    endtask

    task automatic test_timeout();
        exp_t  e;
        outs_t o;
        doLoad(8'd0, 8'd0, 8'd1, 8'd2);
        doStart();
        push("timeout_feed_entry", mk(0, 0, 0, 2, 1, 0, 0));
        push("timeout_still_waiting", mk(0, 0, 0, 2, 1, 0, 0));
        push("timeout_fault", mk(0, 0, 0, 2, 0, 0, 1));
        cyc(4);
        e = sb.pop_front(); o = snap(); totalChecks++;
        if (o !== e.v) $display("[TB] FAIL %s: actual %h required %h", e.name, o, e.v);
        else passedChecks++;
        cyc(11);
        e = sb.pop_front(); o = snap(); totalChecks++;
        if (o !== e.v) $display("[TB] FAIL %s: actual %h required %h", e.name, o, e.v);
        else passedChecks++;
        cyc(1);
        e = sb.pop_front(); o = snap(); totalChecks++;
        if (o !== e.v) $display("[TB] FAIL %s: actual %h required %h", e.name, o, e.v);
        else passedChecks++;
        // Stray done outside FEED and start with a zero time must both be ignored.
        feed_done_i = 1'b1;
        cyc(1);
        feed_done_i = 1'b0;
        doStart();
        push("idle_ignores_done_and_zero_start", mk(0, 0, 0, 2, 0, 0, 1));
        cyc(5);
        e = sb.pop_front(); o = snap(); totalChecks++;
        if (o !== e.v) $display("[TB] FAIL %s: actual %h required %h", e.name, o, e.v);
        else passedChecks++;
        push("load_clears_fault", mk(0, 0, 7, 2, 0, 0, 0));
        doLoad(8'd0, 8'd0, 8'd7, 8'd2);
        e = sb.pop_front(); o = snap(); totalChecks++;
        if (o !== e.v) $display("[TB] FAIL %s: actual %h required %h", e.name, o, e.v);
        else passedChecks++;
    endtask

    task automatic test_start_stop();
        exp_t  e;
        outs_t o;
        start_i = 1'b1;
        stop_i  = 1'b1;
        cyc(1);
        start_i = 1'b0;
        stop_i  = 1'b0;
        push("stop_wins_in_idle", mk(0, 0, 7, 2, 0, 0, 0));
        cyc(8);
        e = sb.pop_front(); o = snap(); totalChecks++;
        if (o !== e.v) $display("[TB] FAIL %s: actual %h required %h", e.name, o, e.v);
        else passedChecks++;
        doLoad(8'd0, 8'd0, 8'd45, 8'd2);
        doStart();
        cyc(20);
        stop_i = 1'b1;
        cyc(1);
        stop_i = 1'b0;
        push("paused_at_40", mk(0, 0, 40, 2, 0, 0, 0));
        cyc(8);
        e = sb.pop_front(); o = snap(); totalChecks++;
        if (o !== e.v) $display("[TB] FAIL %s: actual %h required %h", e.name, o, e.v);
        else passedChecks++;
        doStart();
        push("resume_no_early_tick", mk(0, 0, 40, 2, 0, 0, 0));
        push("resume_full_tick", mk(0, 0, 39, 2, 0, 0, 0));
        cyc(3);
        e = sb.pop_front(); o = snap(); totalChecks++;
        if (o !== e.v) $display("[TB] FAIL %s: actual %h required %h", e.name, o, e.v);
        else passedChecks++;
        cyc(1);
        e = sb.pop_front(); o = snap(); totalChecks++;
        if (o !== e.v) $display("[TB] FAIL %s: actual %h required %h", e.name, o, e.v);
        else passedChecks++;
        stop_i = 1'b1;
        cyc(1);
        stop_i = 1'b0;
    endtask

    task automatic test_async_reset();
        exp_t  e;
        outs_t o;
        outs_t zeroOuts;
        zeroOuts = '0;
        doLoad(8'd0, 8'd0, 8'd1, 8'd1);
        doStart();
        push("pre_reset_feed", mk(0, 0, 0, 1, 1, 0, 0));
        cyc(4);
        e = sb.pop_front(); o = snap(); totalChecks++;
        if (o !== e.v) $display("[TB] FAIL %s: actual %h required %h", e.name, o, e.v);
        else passedChecks++;
        // Assert reset between clock edges; outputs must drop without a clock.
        push("async_reset_mid_feed", zeroOuts);
        #2;
        reset = 1'b0;
        #1;
        e = sb.pop_front(); o = snap(); totalChecks++;
        if (o !== e.v) $display("[TB] FAIL %s: actual %h required %h", e.name, o, e.v);
        else passedChecks++;
        cyc(2);
        reset = 1'b1;
        push("ready_after_second_release", mk(0, 0, 0, 0, 0, 0, 0));
        cyc(1);
        e = sb.pop_front(); o = snap(); totalChecks++;
        if (o !== e.v) $display("[TB] FAIL %s: actual %h required %h", e.name, o, e.v);
        else passedChecks++;
    endtask

    initial begin
        test_reset();
        test_countdown();
        test_expiry();
        test_empty();
        test_timeout();
        test_start_stop();
        test_async_reset();
        $display("%0d/%0d checks passed", passedChecks, totalChecks);
        $finish;
    end

endmodule
